// File: rtl/bhg_fp_clk_divider_mc.sv
// Multi-channel fractional clock divider: each lane runs a fixed-point phase accumulator
// and emits a 50:50 clock plus rise/fall strobes; ratios are reprogrammable glitch-free.

module bhg_fp_clk_divider_lane #(
  parameter int               DIV_W   = 29,
  parameter int               FRAC_W  = 16,
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pend,
  output logic             clk_out,
  output logic             p0,
  output logic             p180
);
  localparam int ACC_W = DIV_W + 1;
  localparam logic [ACC_W-1:0] ONE = ACC_W'(1) << (FRAC_W + 1);
  localparam logic [ACC_W-1:0] TWO = ONE << 1;

  // Half period in accumulator units; ratios below 2.0 are clamped to 2.0.
  function automatic logic [ACC_W-1:0] half_of(input logic [DIV_W-1:0] d);
    logic [ACC_W-1:0] h;
    h = {1'b0, d};
    if (d == '0) return '0;
    if (h < ONE) return ONE;
    return h;
  endfunction

  localparam logic [ACC_W-1:0] RST_HALF = half_of(RST_DIV);

  logic [DIV_W-1:0] div, div_n, shadow, shadow_n, eff;
  logic [ACC_W-1:0] acc, acc_n;
  logic             pend_n, out_n, p0_n, p180_n;

  always_comb begin
    div_n    = div;
    shadow_n = shadow;
    pend_n   = pend;
    acc_n    = acc;
    out_n    = clk_out;
    p0_n     = 1'b0;
    p180_n   = 1'b0;
    eff      = div;
    if (wr)        eff = wr_div;
    else if (pend) eff = shadow;

    if (sync) begin
      if (div != '0 || wr) begin
        div_n  = eff;
        acc_n  = half_of(eff);
        out_n  = 1'b0;
        pend_n = 1'b0;
      end
    end else if (div == '0) begin
      acc_n = '0;
      out_n = 1'b0;
      if (wr) begin
        div_n = wr_div;
        acc_n = half_of(wr_div);
      end
    end else begin
      if (acc >= TWO) begin
        acc_n = acc - ONE;
      end else begin
        out_n  = !clk_out;
        p0_n   = !clk_out;
        p180_n = clk_out;
        // A pending ratio only lands on a rising edge so clk_out never glitches.
        if (!clk_out && pend) begin
          div_n  = shadow;
          pend_n = 1'b0;
          acc_n  = (shadow == '0) ? '0 : acc - ONE + half_of(shadow);
        end else begin
          acc_n = acc - ONE + half_of(div);
        end
      end
      if (wr) begin
        shadow_n = wr_div;
        pend_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= RST_DIV;
      shadow  <= '0;
      pend    <= 1'b0;
      acc     <= RST_HALF;
      clk_out <= 1'b0;
      p0      <= 1'b0;
      p180    <= 1'b0;
    end else begin
      div     <= div_n;
      shadow  <= shadow_n;
      pend    <= pend_n;
      acc     <= acc_n;
      clk_out <= out_n;
      p0      <= p0_n;
      p180    <= p180_n;
    end
  end
endmodule

module bhg_fp_clk_divider_mc #(
  parameter int     CH_N          = 4,
  parameter int     INT_W         = 13,
  parameter int     FRAC_W        = 16,
  parameter longint INPUT_CLK_HZ  = 100000000,
  parameter longint OUTPUT_CLK_HZ = 3579545,
  localparam int    DIV_W         = INT_W + FRAC_W,
  localparam int    CH_W          = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sync_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [CH_N-1:0]  clk_out,
  output logic [CH_N-1:0]  clk_p0,
  output logic [CH_N-1:0]  clk_p180
);
  localparam logic [63:0] RST_DIV64 =
    ((64'(INPUT_CLK_HZ) << FRAC_W) + 64'(OUTPUT_CLK_HZ) / 64'd2) / 64'(OUTPUT_CLK_HZ);
  localparam logic [DIV_W-1:0] RST_DIV = RST_DIV64[DIV_W-1:0];

  logic [CH_N-1:0] pend, wr;

  // Out-of-range channel numbers are accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    if (int'(cfg_ch) < CH_N) cfg_ready = !pend[cfg_ch];
  end

  for (genvar g = 0; g < CH_N; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    bhg_fp_clk_divider_lane #(
      .DIV_W   (DIV_W),
      .FRAC_W  (FRAC_W),
      .RST_DIV (RST_DIV)
    ) u_lane (
      .clk     (clk_in),
      .rst     (rst_in),
      .sync    (sync_in),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .pend    (pend[g]),
      .clk_out (clk_out[g]),
      .p0      (clk_p0[g]),
      .p180    (clk_p180[g])
    );
  end
endmodule
